// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - direction encodings, channel states and pulse selection for servo_multi_drive
package servo_pkg;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_REV  = 2'b10;

  typedef enum logic [1:0] {IDLE, ARMED, RUN} ch_state_t;

  // 2'b11 is treated like DIR_STOP so an unknown direction never drives the motor
  function automatic int unsigned pulse_sel(input logic [1:0] dir,
                                            input int unsigned stop_w,
                                            input int unsigned fwd_w,
                                            input int unsigned rev_w);
    case (dir)
      DIR_FWD:         return fwd_w;
      DIR_REV:         return rev_w;
      DIR_STOP, 2'b11: return stop_w;
      default:         return stop_w;
    endcase
  endfunction

endpackage

// File: rtl/servo_channel.sv
// rtl/servo_channel.sv - one servo channel: command FSM, frame budget, pulse width and pwm output
// Width ramping is built only when SERVO_RAMP_EN is defined.
module servo_channel
  import servo_pkg::*;
#(
  parameter int unsigned W          = 20,
  parameter int unsigned RT_W       = 8,
  parameter int unsigned PULSE_STOP = 40500,
  parameter int unsigned PULSE_FWD  = 45900,
  parameter int unsigned PULSE_REV  = 35100,
  parameter int unsigned RAMP_STEP  = 1350
) (
  input  logic            clk_27,
  input  logic            rst,
  input  logic [W-1:0]    fc,
  input  logic            frame_start,
  input  logic            accept,
  input  logic [1:0]      cmd_dir,
  input  logic [RT_W-1:0] cmd_frames,
  input  logic            abort,
  output logic            idle,
  output logic            busy,
  output logic            done,
  output logic            pwm
);

  localparam logic [W-1:0] W_STOP = W'(PULSE_STOP);
`ifdef SERVO_RAMP_EN
  localparam logic [W-1:0] W_STEP = W'(RAMP_STEP);
`endif

  ch_state_t       state, state_n;
  logic [RT_W-1:0] rem, rem_n, rem_eff;
  logic [W-1:0]    tgt, tgt_n, width, width_n, goal;
  logic            done_n;

  always_ff @(posedge clk_27 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      tgt   <= W_STOP;
      width <= W_STOP;
      done  <= 1'b0;
      pwm   <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      tgt   <= tgt_n;
      width <= width_n;
      done  <= done_n;
      pwm   <= (fc < width);
    end
  end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    tgt_n   = tgt;
    done_n  = 1'b0;
    width_n = width;
    // an abort zeroes the remaining budget right away; the stop lands on the next frame edge
    rem_eff = abort ? '0 : rem;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = ARMED;
          rem_n   = cmd_frames;
          tgt_n   = W'(pulse_sel(cmd_dir, PULSE_STOP, PULSE_FWD, PULSE_REV));
        end
      end
      ARMED, RUN: begin
        rem_n = rem_eff;
        if (frame_start) begin
          if (rem_eff == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = RUN;
            rem_n   = rem_eff - RT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    goal = (state_n == RUN) ? tgt : W_STOP;
    if (frame_start) begin
`ifdef SERVO_RAMP_EN
      if (goal > width)
        width_n = (goal - width > W_STEP) ? width + W_STEP : goal;
      else
        width_n = (width - goal > W_STEP) ? width - W_STEP : goal;
`else
      width_n = goal;
`endif
    end
  end

  assign idle = (state == IDLE);
  assign busy = !idle;

endmodule

// File: rtl/servo_multi_drive.sv
// rtl/servo_multi_drive.sv - NCH-channel timed continuous-rotation servo driver
// Optional width ramping: define SERVO_RAMP_EN.
module servo_multi_drive
  import servo_pkg::*;
#(
  parameter  int unsigned NCH        = 4,
  parameter  int unsigned FRAME_CYC  = 540000,
  parameter  int unsigned PULSE_STOP = 40500,
  parameter  int unsigned PULSE_FWD  = 45900,
  parameter  int unsigned PULSE_REV  = 35100,
  parameter  int unsigned RT_W       = 8,
  parameter  int unsigned RAMP_STEP  = 1350,
  localparam int unsigned CH_W       = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned W          = $clog2(FRAME_CYC)
) (
  input  logic            clk_27,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [CH_W-1:0] cmd_ch,
  input  logic [1:0]      cmd_dir,
  input  logic [RT_W-1:0] cmd_frames,
  input  logic [NCH-1:0]  abort,
  output logic [NCH-1:0]  pwm,
  output logic [NCH-1:0]  busy,
  output logic [NCH-1:0]  done
);

  localparam logic [W-1:0] FC_LAST = W'(FRAME_CYC - 1);

  if (NCH < 1 || NCH > 16 || PULSE_STOP >= FRAME_CYC || PULSE_FWD >= FRAME_CYC ||
      PULSE_REV >= FRAME_CYC || RAMP_STEP == 0) begin : g_bad_cfg
    $error("servo_multi_drive: parameter set out of range");
  end

  logic [W-1:0]   fc;
  logic           frame_start;
  logic [NCH-1:0] idle;
  logic [NCH-1:0] accept;

  always_ff @(posedge clk_27 or posedge rst) begin
    if (rst)                fc <= '0;
    else if (fc == FC_LAST) fc <= '0;
    else                    fc <= fc + W'(1);
  end

  assign frame_start = (fc == '0);

  // channel numbers past NCH-1 match no slot and so are never ready
  always_comb begin
    cmd_ready = 1'b0;
    accept    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cmd_ch == CH_W'(i)) begin
        cmd_ready = idle[i] && !abort[i] && !rst;
        accept[i] = cmd_valid && cmd_ready;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    servo_channel #(
      .W          (W),
      .RT_W       (RT_W),
      .PULSE_STOP (PULSE_STOP),
      .PULSE_FWD  (PULSE_FWD),
      .PULSE_REV  (PULSE_REV),
      .RAMP_STEP  (RAMP_STEP)
    ) u_ch (
      .clk_27      (clk_27),
      .rst         (rst),
      .fc          (fc),
      .frame_start (frame_start),
      .accept      (accept[g]),
      .cmd_dir     (cmd_dir),
      .cmd_frames  (cmd_frames),
      .abort       (abort[g]),
      .idle        (idle[g]),
      .busy        (busy[g]),
      .done        (done[g]),
      .pwm         (pwm[g])
    );
  end

endmodule
